// File: rtl/sift_pkg.sv
// -----------------------------------------------------------------------------
// sift_pkg
// Shared types and constants for the SIFT gradient/keypoint memory fabric.
//   arb_state_t        : arbiter ownership state (OPEN / LOCKED)
//   GRAD_READ_LATENCY  : address-to-data latency of the gradient BRAMs
//   addr_width(dim)    : address width needed for a dim x dim image level
// -----------------------------------------------------------------------------
package sift_pkg;

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int GRAD_READ_LATENCY = 2;

    function automatic int addr_width(input int dim);
        return $clog2(dim * dim);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. Grants the first asserted request found
// when searching cyclically from ptr+1; the requester at ptr has lowest
// priority, so passing the last winner as ptr gives fair rotation.
// Ports:
//   req   : request vector
//   ptr   : index of the most recent winner
//   grant : one-hot grant, or zero when nothing requests
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N = 3,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grad_read_arbiter.sv
// -----------------------------------------------------------------------------
// grad_read_arbiter
// Shares the single read port of an x_grad / y_grad BRAM pair (common address)
// between NUM_REQ requesters. Round-robin per read, with an optional lock that
// lets one requester stream a whole patch uninterrupted. A tag pipeline tracks
// the fixed BRAM latency and steers each returning gradient pair to its issuer.
// Ports:
//   clk, rst_in            : clock, synchronous active-high reset
//   req_valid/addr/lock    : per-requester read request, packed address,
//                            hold-ownership-after-this-beat flag
//   req_ready              : one-hot or zero; issue = req_valid & req_ready
//   rsp_valid              : one-hot or zero; data for that requester now
//   rsp_x_grad/rsp_y_grad  : broadcast BRAM read data (signed, unmodified)
//   bram_addr              : registered shared BRAM read address
//   bram_x_grad/y_grad     : BRAM read data
//   busy                   : locked, or any read still in flight
// -----------------------------------------------------------------------------
module grad_read_arbiter
    import sift_pkg::*;
#(
    parameter int DIMENSION    = 64,
    parameter int BIT_DEPTH    = 8,
    parameter int NUM_REQ      = 3,
    parameter int READ_LATENCY = GRAD_READ_LATENCY,
    localparam int ADDR_WIDTH  = addr_width(DIMENSION),
    localparam int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_in,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic signed [BIT_DEPTH-1:0]   rsp_x_grad,
    output logic signed [BIT_DEPTH-1:0]   rsp_y_grad,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    input  logic signed [BIT_DEPTH-1:0]   bram_x_grad,
    input  logic signed [BIT_DEPTH-1:0]   bram_y_grad,
    output logic                          busy
);

    arb_state_t             state_reg, state_next;
    logic [IDX_W-1:0]       owner_reg, owner_next;
    logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [ADDR_WIDTH-1:0]  bram_addr_reg;

    logic [NUM_REQ-1:0]     rr_grant;
    logic [NUM_REQ-1:0]     ready_c;
    logic [NUM_REQ-1:0]     issue_vec;
    logic                   issue_any;
    logic [IDX_W-1:0]       issue_idx;
    logic [ADDR_WIDTH-1:0]  issue_addr;
    logic                   issue_lock;

    // Tag stage k is visible k+1 cycles after the issue; the last stage lines
    // up with the BRAM data for that address.
    logic                   tag_valid_reg [READ_LATENCY+1];
    logic [IDX_W-1:0]       tag_idx_reg   [READ_LATENCY+1];

    rr_picker #(
        .N (NUM_REQ)
    ) u_rr_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (rr_grant)
    );

    // While locked, only the owner can be served, even if it is idle.
    always_comb begin
        ready_c = '0;
        if (!rst_in) begin
            if (state_reg == LOCKED) begin
                ready_c[owner_reg] = req_valid[owner_reg];
            end else begin
                ready_c = rr_grant;
            end
        end
    end

    assign req_ready = ready_c;
    assign issue_vec = req_valid & ready_c;
    assign issue_any = |issue_vec;

    // issue_vec is one-hot, so a plain loop acts as the select mux.
    always_comb begin
        issue_idx  = '0;
        issue_addr = '0;
        issue_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (issue_vec[i]) begin
                issue_idx  = IDX_W'(i);
                issue_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                issue_lock = req_lock[i];
            end
        end
    end

    // Only the owner can issue while LOCKED, so the same rule covers both
    // entering and leaving the lock.
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        if (issue_any) begin
            rr_ptr_next = issue_idx;
            if (issue_lock) begin
                state_next = LOCKED;
                owner_next = issue_idx;
            end else begin
                state_next = OPEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_reg     <= OPEN;
            owner_reg     <= '0;
            rr_ptr_reg    <= IDX_W'(NUM_REQ - 1);
            bram_addr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            if (issue_any) begin
                bram_addr_reg <= issue_addr;
            end
        end
    end

    assign bram_addr = bram_addr_reg;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            tag_valid_reg[0] <= 1'b0;
            tag_idx_reg[0]   <= '0;
        end else begin
            tag_valid_reg[0] <= issue_any;
            tag_idx_reg[0]   <= issue_idx;
        end
    end

    generate
        for (genvar gi = 1; gi <= READ_LATENCY; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (rst_in) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_idx_reg[gi]   <= '0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_idx_reg[gi]   <= tag_idx_reg[gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        rsp_valid = '0;
        if (!rst_in && tag_valid_reg[READ_LATENCY]) begin
            rsp_valid[tag_idx_reg[READ_LATENCY]] = 1'b1;
        end
    end

    assign rsp_x_grad = bram_x_grad;
    assign rsp_y_grad = bram_y_grad;

    logic in_flight;

    always_comb begin
        in_flight = 1'b0;
        for (int k = 0; k <= READ_LATENCY; k++) begin
            in_flight = in_flight | tag_valid_reg[k];
        end
    end

    assign busy = !rst_in && ((state_reg == LOCKED) || in_flight);

endmodule
